// File: rtl/exmem_pkg.sv
// rtl/exmem_pkg.sv - shared types and defaults for the EX/MEM pipeline register
package exmem_pkg;

    localparam int XLEN_DEF = 64;
    localparam int RA_W_DEF = 5;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    typedef struct packed {
        ctrl_t                 ctrl;
        logic [RA_W_DEF-1:0]   rd;
        logic [XLEN_DEF-1:0]   result;
        logic [XLEN_DEF-1:0]   wdata;
    } entry_t;

    // x0 is hardwired to zero, so a write to it must never reach writeback.
    function automatic ctrl_t strip_x0(input ctrl_t c, input logic rd_is_zero);
        ctrl_t r;
        r           = c;
        r.reg_write = c.reg_write && !rd_is_zero;
        return r;
    endfunction

endpackage

// File: rtl/pipe_skid2.sv
// rtl/pipe_skid2.sv - generic two-entry skid buffer with flush; in_ready is registered
module pipe_skid2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid;
    logic         skid_valid;
    logic [W-1:0] main_data;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         emit;

    // in_ready depends only on the skid flop, so out_ready never reaches it.
    assign in_ready  = !skid_valid;
    assign accept    = in_valid && in_ready;
    assign emit      = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (emit && skid_valid) begin
            // skid full implies in_ready=0, so no accept can coincide here
            main_data  <= skid_data;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
        end else if (accept && (!main_valid || emit)) begin
            main_data  <= in_data;
            main_valid <= 1'b1;
        end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end else if (emit) begin
            main_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/exmem_stage.sv
// rtl/exmem_stage.sv - EX/MEM pipeline register with skid buffer; EXMEM_FWD_EN adds forwarding outputs
module exmem_stage
    import exmem_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_ctrl,
    input  logic [RA_W-1:0] in_rd,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_wdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_ctrl,
    output logic [RA_W-1:0] out_rd,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_wdata
`ifdef EXMEM_FWD_EN
    ,
    output logic            fwd_valid,
    output logic [RA_W-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_data
`endif
);

    localparam int W = CTRL_W + RA_W + 2 * XLEN;

    ctrl_t         ctrl_in;
    ctrl_t         ctrl_main;
    logic [W-1:0]  in_data;
    logic [W-1:0]  main_data;

    assign ctrl_in = strip_x0(ctrl_t'(in_ctrl), in_rd == '0);
    assign in_data = {ctrl_in, in_rd, in_result, in_wdata};

    pipe_skid2 #(
        .W (W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (main_data)
    );

    assign ctrl_main  = ctrl_t'(main_data[W-1 -: CTRL_W]);
    assign out_rd     = main_data[2*XLEN +: RA_W];
    assign out_result = main_data[XLEN +: XLEN];
    assign out_wdata  = main_data[0 +: XLEN];

    // Stale main contents stay in the register; a bubble must not look like a load/store/write.
    assign out_ctrl = out_valid ? ctrl_main : 4'b0000;

`ifdef EXMEM_FWD_EN
    assign fwd_valid = out_valid && ctrl_main.reg_write && !ctrl_main.mem_to_reg;
    assign fwd_rd    = out_rd;
    assign fwd_data  = out_result;
`endif

endmodule
